sp1_ope_serial: RTL and testbench



---
 rtl/sp1_ope_serial_if.sv | 26 ++
 rtl/sp1_ope_serial.sv | 168 ++++++++++++++++
 tb/tb_sp1_ope_serial.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sp1_ope_serial_if.sv
// Request/response bundle for the chunk-serial sp1 operator.
// The master issues operations and consumes results; the slave is the unit.
interface sp1_ope_serial_if #(
  parameter int unsigned DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    op;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] y;
  logic          c;
  logic          flag;

  modport master (
    output req_valid, op, a, b, rsp_ready,
    input  req_ready, rsp_valid, y, c, flag
  );

  modport slave (
    input  req_valid, op, a, b, rsp_ready,
    output req_ready, rsp_valid, y, c, flag
  );
endinterface

// File: rtl/sp1_ope_serial.sv
// Chunk-serial sp1 operator: ADD/SUB/INCR/DECR/EQ/GT on a DW-bit operand pair,
// CW bits per clock, LSB chunk first, with a registered carry and equality chain.
module sp1_ope_serial #(
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 8
) (
  input logic             clk,
  input logic             rst,
  sp1_ope_serial_if.slave bus
);
  localparam int unsigned NCH = DW / CW;
  localparam int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(NCH - 1);

  localparam logic [2:0] OpAdd  = 3'd0;
  localparam logic [2:0] OpSub  = 3'd1;
  localparam logic [2:0] OpIncr = 3'd2;
  localparam logic [2:0] OpDecr = 3'd3;
  localparam logic [2:0] OpEq   = 3'd4;
  localparam logic [2:0] OpGt   = 3'd5;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [2:0]    op_q, op_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic [DW-1:0] y_q, y_d;
  logic          c_q, c_d;
  logic          flag_q, flag_d;
  logic          carry_q, carry_d;
  logic          eq_q, eq_d;

  logic [CW-1:0] a_k, b_k, bp_k;
  logic [CW:0]   sum;
  logic          eq_new;
  logic [DW-1:0] y_full;
  logic          cin_in;

  // Current chunk of each operand, the effective second operand and the chunk sum.
  always_comb begin
    a_k = a_q[int'(idx_q)*CW +: CW];
    b_k = b_q[int'(idx_q)*CW +: CW];
    case (op_q)
      OpAdd:              bp_k = b_k;
      OpSub, OpEq, OpGt:  bp_k = ~b_k;
      OpIncr:             bp_k = '0;
      OpDecr:             bp_k = '1;
      default:            bp_k = '0;
    endcase
    sum    = {1'b0, a_k} + {1'b0, bp_k} + (CW+1)'(carry_q);
    eq_new = eq_q & (a_k == b_k);
    y_full = y_q;
    y_full[int'(idx_q)*CW +: CW] = sum[CW-1:0];
  end

  // Carry-in seeded at acceptance; SUB/INCR/EQ/GT need +1 for two's complement.
  always_comb begin
    case (bus.op)
      OpSub, OpIncr, OpEq, OpGt: cin_in = 1'b1;
      default:                   cin_in = 1'b0;
    endcase
  end

  // Next-state logic: accept, step chunks, finalise, wait for the response handshake.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    c_d     = c_q;
    flag_d  = flag_q;
    carry_d = carry_q;
    eq_d    = eq_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          op_d    = bus.op;
          a_d     = bus.a;
          b_d     = bus.b;
          idx_d   = '0;
          carry_d = cin_in;
          eq_d    = 1'b1;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (idx_q == LastIdx) begin
          state_d = StDone;
          case (op_q)
            OpAdd, OpIncr: begin
              y_d    = y_full;
              c_d    = sum[CW];
              flag_d = (y_full == '0);
            end
            OpSub, OpDecr: begin
              y_d    = y_full;
              c_d    = ~sum[CW];
              flag_d = (y_full == '0);
            end
            OpEq: begin
              y_d    = '0;
              c_d    = 1'b0;
              flag_d = eq_new;
            end
            OpGt: begin
              y_d    = '0;
              c_d    = 1'b0;
              flag_d = sum[CW] & ~eq_new;
            end
            default: begin
              y_d    = '0;
              c_d    = 1'b0;
              flag_d = 1'b0;
            end
          endcase
        end else begin
          y_d     = y_full;
          carry_d = sum[CW];
          eq_d    = eq_new;
          idx_d   = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset; a reset mid-operation drops the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      c_q     <= 1'b0;
      flag_q  <= 1'b0;
      carry_q <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      c_q     <= c_d;
      flag_q  <= flag_d;
      carry_q <= carry_d;
      eq_q    <= eq_d;
    end
  end

  // Handshake and result outputs; req_ready is held low for the whole reset.
  always_comb begin
    bus.req_ready = (state_q == StIdle) & ~rst;
    bus.rsp_valid = (state_q == StDone);
    bus.y         = y_q;
    bus.c         = c_q;
    bus.flag      = flag_q;
  end
endmodule

// File: tb/tb_sp1_ope_serial.sv
// Directed bench for sp1_ope_serial (DW=32, CW=8): latency, results, back-pressure,
// reserved opcode and reset abort. Inputs change and outputs are sampled on negedge.
module tb_sp1_ope_serial;
  localparam int unsigned DW  = 32;
  localparam int unsigned CW  = 8;
  localparam int unsigned NCH = DW / CW;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  sp1_ope_serial_if #(.DW(DW)) bus ();

  sp1_ope_serial #(.DW(DW), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one operation, check exact latency, hold the response for 'hold' cycles,
  // then complete the handshake and check the return to idle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ey, input logic ec,
                        input logic ef, input int hold);
    logic [31:0] y0;
    chk({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    // Scramble operands: only the latched copies may matter.
    bus.op = 3'($urandom);
    bus.a  = $urandom;
    bus.b  = $urandom;
    chk({tag, " busy"}, 32'(bus.req_ready), 32'd0);
    for (int i = 0; i < NCH - 1; i++) begin
      chk({tag, " early"}, 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
    end
    chk({tag, " early"}, 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, " y"}, bus.y, ey);
    chk({tag, " c"}, 32'(bus.c), 32'(ec));
    chk({tag, " flag"}, 32'(bus.flag), 32'(ef));
    y0 = bus.y;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " hold rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({tag, " hold req_ready"}, 32'(bus.req_ready), 32'd0);
      chk({tag, " hold y"}, bus.y, y0);
      chk({tag, " hold c"}, 32'(bus.c), 32'(ec));
      chk({tag, " hold flag"}, 32'(bus.flag), 32'(ef));
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk({tag, " after rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, " after req_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.op        = 3'd0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset y", bus.y, 32'd0);
    chk("reset c", 32'(bus.c), 32'd0);
    chk("reset flag", 32'(bus.flag), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("add_wrap", 3'd0, 32'hffffffff, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 0);
    run_op("add",      3'd0, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0, 0);
    run_op("sub_brw",  3'd1, 32'h00000000, 32'h00000001, 32'hffffffff, 1'b1, 1'b0, 0);
    run_op("sub_zero", 3'd1, 32'ha5a5a5a5, 32'ha5a5a5a5, 32'h00000000, 1'b0, 1'b1, 0);
    run_op("incr",     3'd2, 32'hffffffff, 32'h12345678, 32'h00000000, 1'b1, 1'b1, 0);
    run_op("decr0",    3'd3, 32'h00000000, 32'h00000005, 32'hffffffff, 1'b1, 1'b0, 0);
    run_op("decr100",  3'd3, 32'h00000100, 32'hffffffff, 32'h000000ff, 1'b0, 1'b0, 0);
    run_op("eq_same",  3'd4, 32'h12345678, 32'h12345678, 32'h00000000, 1'b0, 1'b1, 0);
    run_op("eq_top",   3'd4, 32'h12345678, 32'h92345678, 32'h00000000, 1'b0, 1'b0, 0);
    run_op("gt_msb",   3'd5, 32'h80000000, 32'h7fffffff, 32'h00000000, 1'b0, 1'b1, 0);
    run_op("gt_eq",    3'd5, 32'h5a5a5a5a, 32'h5a5a5a5a, 32'h00000000, 1'b0, 1'b0, 0);
    run_op("gt_less",  3'd5, 32'h00000001, 32'h00000100, 32'h00000000, 1'b0, 1'b0, 0);
    run_op("bp_add",   3'd0, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0, 10);
    run_op("rsvd6",    3'd6, 32'hdeadbeef, 32'h01234567, 32'h00000000, 1'b0, 1'b0, 10);

    // Reset two edges into an ADD: the response must never appear.
    bus.req_valid = 1'b1;
    bus.op        = 3'd0;
    bus.a         = 32'h00000010;
    bus.b         = 32'h00000020;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_mid rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_mid y", bus.y, 32'd0);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("rst_mid req_ready after", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("rst_mid no rsp", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b0;
    run_op("post_rst", 3'd0, 32'h00000001, 32'h00000001, 32'h00000002, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
